branch_pc_unit: RTL and testbench

BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

---
 rtl/branch_pc_unit_pkg.sv | 19 +
 rtl/branch_pc_unit_target_adder.sv | 22 ++
 rtl/branch_pc_unit.sv | 112 +++++++++++
 tb/tb_branch_pc_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pc_unit_pkg.sv
// rtl/branch_pc_unit_pkg.sv - shared types and defaults for the branch/PC unit
package branch_pc_unit_pkg;

  localparam int PC_W = 16;
  localparam int DEF_OFFSET_W = 10;
  localparam logic [PC_W-1:0] DEF_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_EVAL    = 2'd2
  } br_state_e;

  // Instructions are halfword aligned, so bit 0 of any PC value is cleared.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] v);
    return v & ~{{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/branch_pc_unit_target_adder.sv
// rtl/branch_pc_unit_target_adder.sv - combinational branch target: base + (sext(offset) << 1)
module branch_target_adder
  import branch_pc_unit_pkg::*;
#(
  parameter int OFFSET_W = DEF_OFFSET_W
) (
  input  logic [PC_W-1:0]     base,
  input  logic [OFFSET_W-1:0] offset,
  output logic [PC_W-1:0]     target
);

  logic [PC_W-1:0] offset_ext;
  logic [PC_W-1:0] byte_offset;

  // Word offset becomes a byte offset; the sum wraps naturally modulo 2^16.
  always_comb begin
    offset_ext  = {{(PC_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
    byte_offset = offset_ext << 1;
    target      = align_pc(base + byte_offset);
  end

endmodule

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - program counter with three-state conditional branch evaluator
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEF_RESET_PC,
  parameter int          OFFSET_W = DEF_OFFSET_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_inc,
  input  logic                pc_load,
  input  logic [15:0]         load_val,
  input  logic                br_req,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic                branch_en,
  output logic [15:0]         pc,
  output logic                br_busy,
  output logic                br_done,
  output logic                br_taken,
  output logic [15:0]         taken_cnt
);

  br_state_e             state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [OFFSET_W-1:0]   offset_q, offset_d;
  logic [PC_W-1:0]       target_q, target_d;
  logic [15:0]           taken_cnt_q, taken_cnt_d;
  logic                  br_done_q, br_done_d;
  logic                  br_taken_q, br_taken_d;
  logic [PC_W-1:0]       adder_target;

  branch_target_adder #(
    .OFFSET_W (OFFSET_W)
  ) u_target_adder (
    .base   (pc_q),
    .offset (offset_q),
    .target (adder_target)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    offset_d    = offset_q;
    target_d    = target_q;
    taken_cnt_d = taken_cnt_q;
    br_done_d   = 1'b0;
    br_taken_d  = 1'b0;

    // A load (jump / exception vector) aborts any branch in flight.
    if (pc_load) begin
      pc_d    = align_pc(load_val);
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pc_inc) begin
            pc_d = pc_q + 16'd2;
          end
          if (br_req) begin
            offset_d = br_offset;
            state_d  = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          target_d = adder_target;
          state_d  = ST_EVAL;
        end
        ST_EVAL: begin
          br_done_d  = 1'b1;
          br_taken_d = branch_en;
          if (branch_en) begin
            pc_d = target_q;
            if (taken_cnt_q != 16'hFFFF) begin
              taken_cnt_d = taken_cnt_q + 16'd1;
            end
          end
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= align_pc(RESET_PC);
      offset_q    <= '0;
      target_q    <= '0;
      taken_cnt_q <= '0;
      br_done_q   <= 1'b0;
      br_taken_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      offset_q    <= offset_d;
      target_q    <= target_d;
      taken_cnt_q <= taken_cnt_d;
      br_done_q   <= br_done_d;
      br_taken_q  <= br_taken_d;
    end
  end

  assign pc        = pc_q;
  assign br_busy   = (state_q != ST_IDLE);
  assign br_done   = br_done_q;
  assign br_taken  = br_taken_q;
  assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - self-checking bench for branch_pc_unit
module tb_branch_pc_unit;

  logic        clk;
  logic        rst;
  logic        pc_inc;
  logic        pc_load;
  logic [15:0] load_val;
  logic        br_req;
  logic [9:0]  br_offset;
  logic        branch_en;
  logic [15:0] pc;
  logic        br_busy;
  logic        br_done;
  logic        br_taken;
  logic [15:0] taken_cnt;

  int checks;
  int errors;

  logic [15:0] model_pc;
  logic [15:0] model_cnt;

  branch_pc_unit #(
    .RESET_PC (16'h0000),
    .OFFSET_W (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .load_val  (load_val),
    .br_req    (br_req),
    .br_offset (br_offset),
    .branch_en (branch_en),
    .pc        (pc),
    .br_busy   (br_busy),
    .br_done   (br_done),
    .br_taken  (br_taken),
    .taken_cnt (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] start_pc;
    logic [9:0]  off;
    logic        en;
    logic [15:0] exp_pc;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sext10(input logic [9:0] o);
    return o[9] ? int'(o) - 1024 : int'(o);
  endfunction

  function automatic logic [15:0] model_target(input logic [15:0] base, input logic [9:0] o);
    int sum;
    sum = int'(base) + 2 * sext10(o);
    return 16'(sum);
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; pc_inc = 1'b0; pc_load = 1'b0; load_val = 16'h0;
    br_req = 1'b0; br_offset = 10'h0; branch_en = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'(model_pc));
    chk({tag, "_cnt"}, 32'(taken_cnt), 32'(model_cnt));
  endtask

  task automatic load_pc(input logic [15:0] v);
    pc_load = 1'b1; load_val = v;
    step();
    pc_load = 1'b0;
    model_pc = v & 16'hFFFE;
    chk("load_pc", 32'(pc), 32'(model_pc));
  endtask

  task automatic do_branch(input logic [9:0] off, input logic en, input logic with_inc);
    logic [15:0] base;
    base = with_inc ? model_pc + 16'd2 : model_pc;
    br_req = 1'b1; br_offset = off; pc_inc = with_inc; branch_en = en;
    step();
    br_req = 1'b0; pc_inc = 1'b0;
    chk("busy_capture", 32'(br_busy), 32'd1);
    chk("done_early", 32'(br_done), 32'd0);
    step();
    chk("done_early2", 32'(br_done), 32'd0);
    step();
    if (en) begin
      model_pc = model_target(base, off);
      if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    end else begin
      model_pc = base;
    end
    chk("br_done", 32'(br_done), 32'd1);
    chk("br_taken", 32'(br_taken), 32'(en));
    chk("busy_after", 32'(br_busy), 32'd0);
    check_state("branch");
    branch_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();

    // Reset overrides simultaneous load/inc/branch request.
    rst = 1'b1; pc_load = 1'b1; load_val = 16'h1234; pc_inc = 1'b1; br_req = 1'b1;
    step(); step();
    idle_inputs();
    model_pc = 16'h0000; model_cnt = 16'h0000;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_busy", 32'(br_busy), 32'd0);
    chk("rst_done", 32'(br_done), 32'd0);
    chk("rst_taken", 32'(br_taken), 32'd0);
    chk("rst_cnt", 32'(taken_cnt), 32'd0);

    // Sequential fetch.
    for (int i = 1; i <= 3; i++) begin
      pc_inc = 1'b1;
      step();
      chk("inc_seq", 32'(pc), 32'(i * 2));
    end
    pc_inc = 1'b0;
    model_pc = 16'h0006;

    vecs[0] = '{16'h0100, 10'h005, 1'b1, 16'h010A, 1'b1};
    vecs[1] = '{16'h0100, 10'h3FC, 1'b0, 16'h0100, 1'b0};
    vecs[2] = '{16'h0000, 10'h3FF, 1'b1, 16'hFFFE, 1'b1};
    vecs[3] = '{16'h0100, 10'h3FC, 1'b1, 16'h00F8, 1'b1};
    vecs[4] = '{16'hFFF0, 10'h010, 1'b1, 16'h0010, 1'b1};
    vecs[5] = '{16'h0200, 10'h200, 1'b1, 16'hFE00, 1'b1};
    vecs[6] = '{16'h1234, 10'h1FF, 1'b1, 16'h1632, 1'b1};
    for (int i = 0; i < 7; i++) begin
      load_pc(vecs[i].start_pc);
      do_branch(vecs[i].off, vecs[i].en, 1'b0);
      chk("vec_pc", 32'(pc), 32'(vecs[i].exp_pc));
      chk("vec_taken", 32'(br_taken), 32'(vecs[i].exp_taken));
    end
    chk("vec_cnt", 32'(taken_cnt), 32'd6);

    // Wrap on increment.
    load_pc(16'hFFFE);
    pc_inc = 1'b1; step(); pc_inc = 1'b0;
    model_pc = 16'h0000;
    chk("inc_wrap", 32'(pc), 32'h0000);

    // Odd load value is aligned; load beats inc.
    pc_load = 1'b1; pc_inc = 1'b1; load_val = 16'h4321;
    step();
    pc_load = 1'b0; pc_inc = 1'b0;
    model_pc = 16'h4320;
    chk("load_over_inc", 32'(pc), 32'h4320);

    // Simultaneous br_req and pc_inc: target based on incremented PC.
    load_pc(16'h0100);
    do_branch(10'h005, 1'b1, 1'b1);
    chk("inc_br_pc", 32'(pc), 32'h010C);

    // Back-to-back: accept again in the cycle br_done is shown.
    br_req = 1'b1; br_offset = 10'h001; branch_en = 1'b0;
    step();
    br_req = 1'b0;
    chk("b2b_busy", 32'(br_busy), 32'd1);
    step(); step();
    chk("b2b_done", 32'(br_done), 32'd1);

    // br_req and pc_inc while busy are ignored.
    br_req = 1'b1; br_offset = 10'h002; branch_en = 1'b0;
    step();
    br_offset = 10'h07F; pc_inc = 1'b1;
    step(); step();
    br_req = 1'b0; pc_inc = 1'b0;
    chk("busy_ign_done", 32'(br_done), 32'd1);
    chk("busy_ign_pc", 32'(pc), 32'(model_pc));
    step();
    chk("busy_ign_noreq", 32'(br_busy), 32'd0);
    chk("busy_ign_nodone", 32'(br_done), 32'd0);

    // pc_load during CAPTURE aborts the branch.
    br_req = 1'b1; br_offset = 10'h005; branch_en = 1'b1;
    step();
    br_req = 1'b0; pc_load = 1'b1; load_val = 16'h2001;
    step();
    pc_load = 1'b0;
    model_pc = 16'h2000;
    chk("abort_cap_pc", 32'(pc), 32'h2000);
    chk("abort_cap_busy", 32'(br_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_cap_nodone", 32'(br_done), 32'd0);
      step();
    end
    check_state("abort_cap");

    // pc_load during EVAL: no done, counter unchanged.
    br_req = 1'b1; br_offset = 10'h005; branch_en = 1'b1;
    step();
    br_req = 1'b0;
    step();
    pc_load = 1'b1; load_val = 16'h3000;
    step();
    pc_load = 1'b0; branch_en = 1'b0;
    model_pc = 16'h3000;
    chk("abort_eval_done", 32'(br_done), 32'd0);
    check_state("abort_eval");

    // Counter saturation: preset near the top, then two taken branches.
    force dut.taken_cnt_q = 16'hFFFE;
    step();
    release dut.taken_cnt_q;
    model_cnt = 16'hFFFE;
    chk("preset_cnt", 32'(taken_cnt), 32'hFFFE);
    do_branch(10'h001, 1'b1, 1'b0);
    chk("sat_first", 32'(taken_cnt), 32'hFFFF);
    do_branch(10'h001, 1'b1, 1'b0);
    chk("sat_hold", 32'(taken_cnt), 32'hFFFF);

    // Randomized traffic against the arithmetic model.
    for (int n = 0; n < 200; n++) begin
      int op;
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          int k;
          k = int'($urandom_range(1, 3));
          pc_inc = 1'b1;
          for (int j = 0; j < k; j++) step();
          pc_inc = 1'b0;
          model_pc = model_pc + 16'(2 * k);
          chk("rnd_inc", 32'(pc), 32'(model_pc));
        end
        1: load_pc(16'($urandom()));
        2: do_branch(10'($urandom()), 1'($urandom()), 1'b0);
        default: do_branch(10'($urandom()), 1'($urandom()), 1'b1);
      endcase
    end

    // Reset mid-branch aborts without br_done.
    br_req = 1'b1; br_offset = 10'h010; branch_en = 1'b1;
    step();
    br_req = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; branch_en = 1'b0;
    model_pc = 16'h0000; model_cnt = 16'h0000;
    chk("midrst_busy", 32'(br_busy), 32'd0);
    chk("midrst_done", 32'(br_done), 32'd0);
    step();
    chk("midrst_done2", 32'(br_done), 32'd0);
    check_state("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
